// File: rtl/subpel_pkg.sv
// Shared definitions for the sub-pixel interpolation datapath: plane codes,
// beat width, the {c,b,a} result triple and default frame geometry.
package subpel_pkg;

    localparam logic [1:0] PLANE_A = 2'd0;
    localparam logic [1:0] PLANE_B = 2'd1;
    localparam logic [1:0] PLANE_C = 2'd2;

    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned TRIPLE_W = 3 * BEAT_W;

    localparam int unsigned DEF_ROW_BEATS  = 40;
    localparam int unsigned DEF_FRAME_ROWS = 720;

    typedef struct packed {
        logic [BEAT_W-1:0] c;
        logic [BEAT_W-1:0] b;
        logic [BEAT_W-1:0] a;
    } triple_t;

    // Select one plane's beat out of a triple.
    function automatic logic [BEAT_W-1:0] triple_beat(input triple_t t, input logic [1:0] plane);
        logic [BEAT_W-1:0] beat;
        case (plane)
            PLANE_A: beat = t.a;
            PLANE_B: beat = t.b;
            PLANE_C: beat = t.c;
            default: beat = '0;
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/subpel_triple_fifo.sv
// Synchronous FIFO for interpolator result triples. Level is registered;
// full/empty are decoded from it. head_next_c previews the head entry as it
// will be after this cycle's push/pop, so the consumer can register its
// outputs with no extra latency.
module subpel_triple_fifo #(
    parameter int unsigned WIDTH = 192,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);
    assign do_push_c = push && !full_c && !flush;
    assign do_pop_c  = pop && !empty_c && !flush;

    // Preview of the head entry after this edge, bypassing a push into an empty slot.
    always_comb begin
        rd_next_c   = do_pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        head_next_c = mem[rd_next_c];
        if (do_push_c && (wr_ptr == rd_next_c)) begin
            head_next_c = din;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
        end
    end

endmodule

// File: rtl/subpel_out_writer.sv
// Output writer for the sub-pixel interpolator: buffers {c,b,a} result
// triples and streams them as plane A/B/C beats to a ready/valid write port
// with frame addresses. Optional build macro SUBPEL_OVF_CNT_EN adds a
// saturating 16-bit dropped-triple counter port (ovf_cnt).
module subpel_out_writer
    import subpel_pkg::*;
#(
    parameter int unsigned ROW_BEATS  = DEF_ROW_BEATS,
    parameter int unsigned FRAME_ROWS = DEF_FRAME_ROWS,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load_out,
    input  logic [BEAT_W-1:0]       fir_out_a,
    input  logic [BEAT_W-1:0]       fir_out_b,
    input  logic [BEAT_W-1:0]       fir_out_c,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [1:0]              wr_plane,
    output logic [BEAT_W-1:0]       wr_data,
    output logic                    frame_done,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  fifo_level
`ifdef SUBPEL_OVF_CNT_EN
    ,
    output logic [15:0]             ovf_cnt
`endif
);

    localparam int unsigned LVL_W        = $clog2(DEPTH) + 1;
    localparam int unsigned BEAT_CW      = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int unsigned ROW_CW       = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam int unsigned PLANE_STRIDE = ROW_BEATS * FRAME_ROWS;

    logic [BEAT_CW-1:0] beat;
    logic [ROW_CW-1:0]  row;

    logic               full_c;
    logic               empty_c;
    triple_t            head_next_c;
    logic               accept_c;
    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    logic [1:0]         plane_next_c;
    logic [BEAT_CW-1:0] beat_next_c;
    logic [ROW_CW-1:0]  row_next_c;
    logic               frame_end_c;
    logic [LVL_W-1:0]   level_next_c;
    logic               valid_next_c;
    logic [ADDR_W-1:0]  addr_next_c;

    assign accept_c = wr_valid && wr_ready && !clr;
    assign pop_c    = accept_c && (wr_plane == PLANE_C) && !empty_c;
    assign push_c   = load_out && !clr;
    assign drop_c   = load_out && !clr && full_c;

    subpel_triple_fifo #(
        .WIDTH (TRIPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (clr),
        .push        (push_c),
        .din         ({fir_out_c, fir_out_b, fir_out_a}),
        .pop         (pop_c),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .level       (fifo_level),
        .head_next_c (head_next_c)
    );

    // Next plane/beat/row position and frame-end detection.
    always_comb begin
        plane_next_c = wr_plane;
        beat_next_c  = beat;
        row_next_c   = row;
        frame_end_c  = 1'b0;
        if (clr) begin
            plane_next_c = PLANE_A;
            beat_next_c  = '0;
            row_next_c   = '0;
        end else if (accept_c) begin
            plane_next_c = (wr_plane == PLANE_C) ? PLANE_A : (wr_plane + 2'd1);
            if (pop_c) begin
                if (beat == BEAT_CW'(ROW_BEATS - 1)) begin
                    beat_next_c = '0;
                    if (row == ROW_CW'(FRAME_ROWS - 1)) begin
                        row_next_c  = '0;
                        frame_end_c = 1'b1;
                    end else begin
                        row_next_c = row + ROW_CW'(1);
                    end
                end else begin
                    beat_next_c = beat + BEAT_CW'(1);
                end
            end
        end
    end

    // Next occupancy and write address, full-width before the final cast.
    always_comb begin
        level_next_c = '0;
        if (!clr) begin
            level_next_c = fifo_level + LVL_W'(push_c && !full_c) - LVL_W'(pop_c);
        end
        valid_next_c = (level_next_c != '0);
        addr_next_c  = ADDR_W'(32'(plane_next_c) * PLANE_STRIDE
                              + 32'(row_next_c) * ROW_BEATS
                              + 32'(beat_next_c));
    end

    // Registered write port, position counters and frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_valid   <= 1'b0;
            wr_plane   <= PLANE_A;
            wr_addr    <= '0;
            wr_data    <= '0;
            beat       <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_valid   <= valid_next_c;
            wr_plane   <= plane_next_c;
            wr_addr    <= addr_next_c;
            wr_data    <= valid_next_c ? triple_beat(head_next_c, plane_next_c) : '0;
            beat       <= beat_next_c;
            row        <= row_next_c;
            frame_done <= frame_end_c;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end
    end

`ifdef SUBPEL_OVF_CNT_EN
    // Saturating count of dropped triples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt <= '0;
        end else if (clr) begin
            ovf_cnt <= '0;
        end else if (drop_c && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
